truth_table_scanner: RTL
========================

Name: truth_table_scanner

Overview:
- Sequencer that drives a 4-variable combinational function block (X, Y, W, Z -> S) through all input codes 0..15.
- Samples S after a programmable settle time and assembles the 16-entry truth table in a register, reporting its count of ones (minterm count).
- Sits between a control/test host and one combinational PoS/SoP block, replacing hand-written stimulus sequences with a start/done handshake.

Parameters:
- VARS, 4, number of function inputs; table width is 2**VARS.
- SETTLE, 1, cycles each input code is held before S is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a scan; sampled only in IDLE
- abort  input  1  synchronous cancel of a running scan
- s  input  1  output S of the function under scan
- vars  output  VARS  drive to function inputs; vars[3]=X, vars[2]=Y, vars[1]=W, vars[0]=Z
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse when the table is complete
- table_valid  output  1  level; table holds a full, unaborted scan
- table  output  2**VARS  bit i = S sampled with vars==i
- ones_count  output  VARS+1  number of ones in table, valid with table_valid

Behaviour:
- Reset (asynchronous, any time, including mid-scan): state IDLE; vars=0, busy=0, done=0, table_valid=0, table=0, ones_count=0, index=0, settle counter=0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: busy=0. start=1 at an edge -> APPLY; index<=0, vars<=0, table<=0, table_valid<=0, ones_count<=0, busy<=1.
- APPLY: vars holds index. Remains exactly SETTLE cycles (counter 0..SETTLE-1), then -> SAMPLE.
- SAMPLE: table[index]<=s; ones_count increments when s=1. If index==2**VARS-1 -> DONE; else index<=index+1, vars<=index+1, -> APPLY.
- DONE: done=1 and table_valid<=1 for this one cycle; busy<=0; next -> IDLE.
- Timing: each code occupies SETTLE+1 cycles; done is high in cycle 2**VARS*(SETTLE+1)+1 after the start edge (33 with defaults).
- start while busy: ignored. start asserted in the DONE cycle: ignored. start held high: a new scan begins from the next IDLE cycle.
- abort=1 in APPLY or SAMPLE -> IDLE next edge. busy<=0, table_valid stays 0, no done pulse. The partial table is kept but is invalid. The SAMPLE write in the abort cycle is suppressed. abort takes priority over start, and abort in IDLE or DONE has no effect.
- s is X/Z at sample: the stored bit follows simulator semantics, with no special handling.
- vars after a scan: holds the last code (2**VARS-1) until the next start; after abort it holds the aborted code.

Optional Feature:
- Macro TTS_COMPARE_EN.
- Defined: adds input expected[2**VARS-1:0] and outputs mismatch (1 bit) and first_mismatch (VARS bits).
- expected is sampled at start. During SAMPLE, if s != expected[index] and no mismatch has been recorded yet, first_mismatch<=index and mismatch<=1.
- Both are cleared on start and on reset, and are meaningful when table_valid=1.
- Undefined: those ports and logic are absent, and the block behaves as described above.

Test Plan:
- Reset mid-scan: start, then pulse reset at cycle 10 -> all outputs 0 immediately (asynchronous); idle until the next start.
- Scan of PoS with maxterms 0,1,2,4,7,12,15, SETTLE=1: start pulse -> busy=1, vars steps 0..15 every 2 cycles; done at cycle 33; table=16'h6F68, ones_count=9, table_valid=1.
- Constant s=1, SETTLE=3 -> done at cycle 65, table=16'hFFFF, ones_count=16; constant s=0 -> table=0, ones_count=0.
- Abort at cycle 12 -> busy=0 next cycle, no done, table_valid=0; a new start rescans from vars=0 and completes normally.
- start re-pulsed at cycles 5 and 20 during a scan -> ignored, single done at cycle 33; start held high continuously -> back-to-back scans, each done 34 cycles apart.
- TTS_COMPARE_EN with expected=16'h6F68 and the PoS function -> mismatch=0. With expected=16'h6F69 -> mismatch=1, first_mismatch=0.

Source files
------------

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Steps a 4-variable combinational block through every input code and
//   collects its truth table. Each code is driven on vars for SETTLE cycles.
//   The block's output s is then sampled into truth_table[code]. When all
//   2**VARS codes are done, done pulses for one cycle and table_valid rises.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          begin a scan (sampled only while idle)
//   abort          cancel a running scan; the partial table stays invalid
//   s              output of the function under scan
//   vars           drive to the function: [3]=X, [2]=Y, [1]=W, [0]=Z
//   busy           high from the start edge until the scan ends or is aborted
//   done           one-cycle pulse when the table is complete
//   table_valid    the table holds a full, unaborted scan
//   truth_table    bit i = s sampled while vars == i
//   ones_count     number of ones in truth_table (minterm count)
//
// Optional feature, enabled by defining TTS_COMPARE_EN:
//   expected       reference table, captured at start
//   mismatch       some sampled s differed from the reference
//   first_mismatch lowest code at which the difference occurred
module truth_table_scanner #(
   parameter int VARS   = 4,
   parameter int SETTLE = 1    // legal range 1..15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 s,
`ifdef TTS_COMPARE_EN
   input  logic [2**VARS-1:0]   expected,
   output logic                 mismatch,
   output logic [VARS-1:0]      first_mismatch,
`endif
   output logic [VARS-1:0]      vars,
   output logic                 busy,
   output logic                 done,
   output logic                 table_valid,
   output logic [2**VARS-1:0]   truth_table,
   output logic [VARS:0]        ones_count
);

   localparam int              ENTRIES     = 2**VARS;
   localparam logic [VARS-1:0] LAST_CODE   = VARS'(ENTRIES - 1);
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   state_t              state_reg, state_next;
   logic [VARS-1:0]     index_reg;
   logic [3:0]          settle_reg;
   logic [VARS:0]       ones_reg;
   logic                valid_reg;
   logic [ENTRIES-1:0]  table_reg, table_next;

   logic start_scan;
   logic sample_en;

   assign start_scan = (state_reg == IDLE) && start;
   // An abort in SAMPLE wins over the write of that cycle.
   assign sample_en  = (state_reg == SAMPLE) && !abort;

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = APPLY;
         APPLY: begin
            if (abort)                          state_next = IDLE;
            else if (settle_reg == SETTLE_LAST) state_next = SAMPLE;
         end
         SAMPLE: begin
            if (abort)                        state_next = IDLE;
            else if (index_reg == LAST_CODE)  state_next = DONE;
            else                              state_next = APPLY;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- table bits ----------------
   // Each bit is cleared when a scan starts and written only when the
   // sample index addresses it.
   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_table
         assign table_next[gi] = start_scan ? 1'b0 :
                                 (sample_en && (index_reg == VARS'(gi))) ? s :
                                 table_reg[gi];
      end
   endgenerate

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index_reg  <= '0;
         settle_reg <= '0;
         ones_reg   <= '0;
         valid_reg  <= 1'b0;
         table_reg  <= '0;
      end else begin
         table_reg <= table_next;
         if (start_scan) begin
            index_reg  <= '0;
            settle_reg <= '0;
            ones_reg   <= '0;
            valid_reg  <= 1'b0;
         end else begin
            // Settle counter runs 0..SETTLE-1 while a code is applied.
            if ((state_reg == APPLY) && !abort && (settle_reg != SETTLE_LAST))
               settle_reg <= settle_reg + 4'd1;
            else
               settle_reg <= '0;

            if (sample_en) begin
               if (s == 1'b1)
                  ones_reg <= ones_reg + (VARS+1)'(1);
               // The last code is held on vars after a completed scan.
               if (index_reg == LAST_CODE)
                  valid_reg <= 1'b1;
               else
                  index_reg <= index_reg + VARS'(1);
            end
         end
      end
   end

`ifdef TTS_COMPARE_EN
   logic [ENTRIES-1:0] expected_reg;
   logic               mismatch_reg;
   logic [VARS-1:0]    first_mismatch_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         expected_reg       <= '0;
         mismatch_reg       <= 1'b0;
         first_mismatch_reg <= '0;
      end else if (start_scan) begin
         expected_reg       <= expected;
         mismatch_reg       <= 1'b0;
         first_mismatch_reg <= '0;
      end else if (sample_en && !mismatch_reg && (s != expected_reg[index_reg])) begin
         mismatch_reg       <= 1'b1;
         first_mismatch_reg <= index_reg;
      end
   end

   assign mismatch       = mismatch_reg;
   assign first_mismatch = first_mismatch_reg;
`endif

   // ---------------- outputs ----------------
   assign vars        = index_reg;
   assign busy        = (state_reg != IDLE);
   assign done        = (state_reg == DONE);
   assign table_valid = valid_reg;
   assign truth_table = table_reg;
   assign ones_count  = ones_reg;

endmodule
